// File: rtl/i2c_slave_rx_if.sv
// Write-strobe port group of the I2C target receiver: one received
// register write (pointer + data) plus the bus-activity flag.
interface i2c_slave_rx_if;
    // wr_valid is a one-cycle strobe with no back-pressure: the consumer
    // must take wr_sub/wr_data in the cycle wr_valid is high. Both fields
    // keep their value until the next strobe.
    logic       wr_valid;
    logic [7:0] wr_sub;
    logic [7:0] wr_data;
    logic       busy;

    // Target side: produces the writes.
    modport slave (
        output wr_valid,
        output wr_sub,
        output wr_data,
        output busy
    );

    // Register-file side: consumes the writes.
    modport master (
        input wr_valid,
        input wr_sub,
        input wr_data,
        input busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C target receiver (write-only). SCL/SDA are oversampled on clk, START
// and STOP are detected in every state, the 7-bit device address is
// matched, and each data byte is emitted as a one-cycle write strobe
// together with an auto-incrementing register pointer. Reads are NACKed.
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h68
) (
    input  logic           clk,
    input  logic           reset,      // asynchronous, active low
    input  logic           i2c_scl,
    inout  wire            i2c_sda,
    i2c_slave_rx_if.slave  wr_if,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_SUB    = 3'd2,
        ST_DATA   = 3'd3,
        ST_ACK    = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    // Synchronizer stages plus one delayed copy for edge detection.
    logic scl_s1_q, scl_s2_q, scl_dly_q;
    logic sda_s1_q, sda_s2_q, sda_dly_q;
    logic scl_s1_d, scl_s2_d, scl_dly_d;
    logic sda_s1_d, sda_s2_d, sda_dly_d;

    // Receiver state.
    state_t     state_q, state_d;
    state_t     pend_q, pend_d;        // byte phase entered after the ACK slot
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;      // first seven bits of the current byte
    logic [7:0] ptr_q, ptr_d;          // register pointer
    logic       sda_oe_q, sda_oe_d;    // 1 = pulling SDA low
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_sub_q, wr_sub_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;
    logic [7:0] byte_in;

    // Bus condition decode from the synchronized samples.
    always_comb begin
        scl_rise  = scl_s2_q & ~scl_dly_q;
        scl_fall  = ~scl_s2_q & scl_dly_q;
        start_det = scl_s2_q & scl_dly_q & ~sda_s2_q & sda_dly_q;
        stop_det  = scl_s2_q & scl_dly_q & sda_s2_q & ~sda_dly_q;
        byte_in   = {shift_q, sda_s2_q};
    end

    // Synchronizer next values.
    always_comb begin
        scl_s1_d  = i2c_scl;
        scl_s2_d  = scl_s1_q;
        scl_dly_d = scl_s2_q;
        sda_s1_d  = i2c_sda;
        sda_s2_d  = sda_s1_q;
        sda_dly_d = sda_s2_q;
    end

    // Receiver next-state: START/STOP win over any bit-sampling edge.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_sub_d   = wr_sub_q;
        wr_data_d  = wr_data_q;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                                    state_d = ST_ACK;
                                    pend_d  = ST_SUB;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_SUB) begin
                                ptr_d   = byte_in;
                                state_d = ST_ACK;
                                pend_d  = ST_DATA;
                            end else begin
                                wr_valid_d = 1'b1;
                                wr_data_d  = byte_in;
                                wr_sub_d   = ptr_q;
                                ptr_d      = ptr_q + 8'd1;
                                state_d    = ST_ACK;
                                pend_d     = ST_DATA;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    // First falling edge starts pulling SDA low; the falling
                    // edge that ends the 9th clock releases it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            state_d   = pend_q;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_dly_q  <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_dly_q  <= 1'b1;
            state_q    <= ST_IDLE;
            pend_q     <= ST_SUB;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_sub_q   <= 8'd0;
            wr_data_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            scl_dly_q  <= scl_dly_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            sda_dly_q  <= sda_dly_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_sub_q   <= wr_sub_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    // Open-drain SDA: only ever 0 or released.
    assign i2c_sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_if.wr_valid = wr_valid_q;
    assign wr_if.wr_sub   = wr_sub_q;
    assign wr_if.wr_data  = wr_data_q;
    assign wr_if.busy     = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bit-banged I2C master, scoreboard of
// expected (pointer, data) writes, immediate-assertion checks.
module tb_i2c_slave_rx;

    localparam int Q = 40;  // quarter SCL period in ns (SCL = 16 clk)

    logic        clk;
    logic        reset;
    logic        scl;
    logic        sda_low;
    wire         i2c_sda;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    i2c_slave_rx_if wr_if();

    assign i2c_sda = sda_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_slave_rx #(.DEV_ADDR(7'h68)) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (scl),
        .i2c_sda   (i2c_sda),
        .wr_if     (wr_if),
        .dbg_state (dbg_state)
    );

    // Clock: posedges at 5 mod 10 ns, bus stimulus lands on 0 mod 10 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must have been predicted, in order.
    always @(negedge clk) begin
        logic [15:0] exp_val;
        if (reset && wr_if.wr_valid) begin
            check("strobe_expected", {15'd0, (exp_q.size() != 0)}, 16'd1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                check("strobe_sub_data", {wr_if.wr_sub, wr_if.wr_data}, exp_val);
            end
        end
    end

    task automatic i2c_start();
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q sda_low = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
        #Q;
    endtask

    // Eight data bits then the 9th clock; ack_exp: 1 = target must pull low.
    task automatic write_byte(input logic [7:0] b, input logic ack_exp, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q check(tag, {15'd0, i2c_sda}, ack_exp ? 16'd0 : 16'd1);
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic stop_and_check_idle(input string tag);
        i2c_stop();
        #32 check(tag, {15'd0, wr_if.busy}, 16'd0);
        #8;
    endtask

    task automatic case1(input string pfx);
        i2c_start();
        write_byte(8'hD0, 1'b1, {pfx, "_addr_ack"});
        write_byte(8'h20, 1'b1, {pfx, "_sub_ack"});
        exp_q.push_back(16'h200F);
        write_byte(8'h0F, 1'b1, {pfx, "_data_ack"});
        check({pfx, "_busy_before_stop"}, {15'd0, wr_if.busy}, 16'd1);
        stop_and_check_idle({pfx, "_busy_after_stop"});
        check({pfx, "_queue_empty"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        reset   = 1'b0;
        scl     = 1'b1;
        sda_low = 1'b0;
        #20;
        check("rst_sda_released", {15'd0, i2c_sda}, 16'd1);
        check("rst_busy", {15'd0, wr_if.busy}, 16'd0);
        check("rst_wr", {7'd0, wr_if.wr_valid, wr_if.wr_sub}, 16'd0);
        check("rst_wr_data", {8'd0, wr_if.wr_data}, 16'd0);
        #20 reset = 1'b1;
        #(2*Q);

        // 1: addressed write of one byte
        case1("c1");
        check("c1_hold_sub_data", {wr_if.wr_sub, wr_if.wr_data}, 16'h200F);

        // 2: other device, never ACKed, no strobe
        i2c_start();
        write_byte(8'hA0, 1'b0, "c2_addr_nack");
        check("c2_busy_ignore", {15'd0, wr_if.busy}, 16'd1);
        write_byte(8'h20, 1'b0, "c2_sub_nack");
        write_byte(8'h0F, 1'b0, "c2_data_nack");
        check("c2_busy_before_stop", {15'd0, wr_if.busy}, 16'd1);
        stop_and_check_idle("c2_busy_after_stop");
        check("c2_queue_empty", 16'(exp_q.size()), 16'd0);

        // 3: read request NACKed, subsequent bytes ignored
        i2c_start();
        write_byte(8'hD1, 1'b0, "c3_read_nack");
        write_byte(8'h55, 1'b0, "c3_ignored_nack");
        check("c3_busy_ignore", {15'd0, wr_if.busy}, 16'd1);
        stop_and_check_idle("c3_busy_after_stop");

        // 4: burst with pointer wrap 0xFF -> 0x00
        i2c_start();
        write_byte(8'hD0, 1'b1, "c4_addr_ack");
        write_byte(8'hFE, 1'b1, "c4_sub_ack");
        exp_q.push_back(16'hFE11);
        write_byte(8'h11, 1'b1, "c4_d0_ack");
        exp_q.push_back(16'hFF22);
        write_byte(8'h22, 1'b1, "c4_d1_ack");
        exp_q.push_back(16'h0033);
        write_byte(8'h33, 1'b1, "c4_d2_ack");
        stop_and_check_idle("c4_busy_after_stop");
        check("c4_queue_empty", 16'(exp_q.size()), 16'd0);

        // 5: partial byte cut by repeated START
        i2c_start();
        write_byte(8'hD0, 1'b1, "c5_addr_ack");
        write_byte(8'h10, 1'b1, "c5_sub_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_start();
        write_byte(8'hD0, 1'b1, "c5_rs_addr_ack");
        write_byte(8'h40, 1'b1, "c5_rs_sub_ack");
        exp_q.push_back(16'h4055);
        write_byte(8'h55, 1'b1, "c5_data_ack");
        stop_and_check_idle("c5_busy_after_stop");
        check("c5_queue_empty", 16'(exp_q.size()), 16'd0);

        // 6: async reset while the sub-address ACK is being driven
        i2c_start();
        write_byte(8'hD0, 1'b1, "c6_addr_ack");
        for (int i = 7; i >= 0; i--) send_bit(i == 5);
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q check("c6_ack_before_reset", {15'd0, i2c_sda}, 16'd0);
        reset = 1'b0;
        #1;
        check("c6_sda_released_async", {15'd0, i2c_sda}, 16'd1);
        check("c6_busy_async", {15'd0, wr_if.busy}, 16'd0);
        check("c6_wr_async", {wr_if.wr_sub, wr_if.wr_data}, 16'd0);
        check("c6_valid_async", {15'd0, wr_if.wr_valid}, 16'd0);
        #(Q-1) scl = 1'b0;
        #Q reset = 1'b1;
        #(2*Q);
        case1("c6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C target (slave) receiver, the write-side counterpart of the team's I2C master.
- Oversamples SCL/SDA on the system clock. Detects START and STOP conditions.
- Matches the 7-bit device address and ACKs address, sub-address and data bytes.
- Presents each received data byte with its register pointer as a one-cycle strobe to an external register file. Pointer auto-increments for burst writes. Read requests are NACKed.

Parameters:
- DEV_ADDR, 7'h68, 7-bit device address this target answers to.

Ports:
- clk  input  1  system clock; must be at least 8x SCL frequency.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i2c_scl  input  1  bus clock; the target never drives or stretches SCL.
- i2c_sda  inout  1  bus data, open-drain: driven 0 or Z only.
- wr_valid  output  1  one-cycle strobe: wr_sub/wr_data hold a received write.
- wr_sub  output  8  register pointer for the current write.
- wr_data  output  8  received data byte.
- busy  output  1  high while a transaction addressed or in progress (state != IDLE).

Behaviour:
- Reset (reset==0, async):
  - SDA released (Z); state=IDLE; wr_valid=0, wr_sub=0, wr_data=0, busy=0.
  - Synchronizer flops = 1; bit counter = 0.
  - Takes effect immediately, including mid-ACK.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer, plus one delayed copy for edge detection.
  - scl_rise = sync high & delayed low; scl_fall = the inverse.
- START: SCL sync high on both samples and SDA falls. Legal in any state, including a repeated START. Action: release SDA, go to ADDR, bit count 0, discard any partial byte.
- STOP: SCL high and SDA rises. Legal in any state. Action: release SDA, go to IDLE, busy=0 next cycle.
- START/STOP take priority over any simultaneous bit-sampling edge.
- Bit reception: shift SDA in on scl_rise, MSB first; 8 bits per byte. Byte complete on the 8th scl_rise.
- States:
  - IDLE: wait for START.
  - ADDR: receive 8 bits [7:1]=address, [0]=R/W. On completion:
    - match with R/W=0: set ack flag, next byte phase = SUB;
    - mismatch or R/W=1: go to IGNORE, SDA never driven.
  - ACK: on the scl_fall after the 8th bit, drive SDA=0. Hold until the next scl_fall (the 9th clock), then release and enter the pending byte phase (SUB or DATA).
  - SUB: receive byte into the pointer register, then ACK, then DATA.
  - DATA: on the 8th scl_rise, register wr_data=byte, wr_sub=pointer, wr_valid=1 for exactly one clk. Pointer then increments mod 256 (0xFF wraps to 0x00). Then ACK, then DATA again (burst).
  - IGNORE: no driving, no strobes; leave only on START (to ADDR) or STOP (to IDLE).
- Latency: wr_valid rises 1 clk after the synchronized 8th scl_rise is detected, i.e. about 3 clk after the pad edge.
- wr_sub/wr_data hold their value until the next strobe.
- Partial bytes interrupted by START/STOP produce no strobe and no pointer change.
- busy=1 in every state except IDLE, including IGNORE.

Test Plan:
1. START, 0xD0 (addr 0x68, W), 0x20, 0x0F, STOP:
   - SDA pulled low during all three 9th clocks;
   - exactly one wr_valid, with wr_sub=0x20, wr_data=0x0F;
   - busy=0 within 3 clk of STOP.
2. START, 0xA0 (addr 0x50), 0x20, 0x0F, STOP:
   - SDA never driven low by the DUT;
   - no wr_valid; busy high until STOP.
3. START, 0xD1 (read to 0x68):
   - NACK (SDA stays high on 9th clock);
   - DUT enters IGNORE; no strobes until STOP.
4. Burst: START, 0xD0, 0xFE, 0x11, 0x22, 0x33, STOP:
   - three wr_valid pulses with (sub,data) = (0xFE,0x11), (0xFF,0x22), (0x00,0x33).
5. START, 0xD0, 0x10, 3 data bits, repeated START, 0xD0, 0x40, 0x55, STOP:
   - partial byte discarded;
   - single wr_valid with sub=0x40, data=0x55.
6. reset driven low while DUT drives the sub-address ACK:
   - SDA goes Z in the same cycle, without waiting for a clk edge;
   - busy=0, wr_* = 0;
   - after release, a case-1 transaction completes normally.
